// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: blocking instruction-memory read handshake with a one-entry decode buffer.
// Optional FETCH_MISALIGN_EN: an odd redirect target raises sticky fetch_err and halts fetch.
module fetch_pc_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [4:0]  HALT_OP  = 5'b00000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] next_pc,
   input  logic        redirect,
   input  logic        dec_stall,
   output logic        imem_rd,
   output logic [15:0] imem_addr,
   input  logic        imem_done,
   input  logic [15:0] imem_data,
   output logic [15:0] instr,
   output logic [15:0] pc_inc,
   output logic        instr_valid,
   output logic        halted,
   output logic        fetch_err
);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } state_e;

   localparam logic [15:0] NOP = 16'h0800;

   state_e      state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] instr_q, instr_d;
   logic [15:0] pc_inc_q, pc_inc_d;
   logic        valid_q, valid_d;
   logic        busy_q, busy_d;
   logic        squash_q, squash_d;
   logic        halted_q, halted_d;
`ifdef FETCH_MISALIGN_EN
   logic        fetch_err_q, fetch_err_d;
`endif

   logic in_run, redir, launch, done, capture, consume;

   always_comb begin
      // NOTE: every _d takes its _q first so no path through this block can infer a latch.
      state_d  = state_q;
      pc_d     = pc_q;
      addr_d   = addr_q;
      instr_d  = instr_q;
      pc_inc_d = pc_inc_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      squash_d = squash_q;
      halted_d = halted_q;
`ifdef FETCH_MISALIGN_EN
      fetch_err_d = fetch_err_q;
`endif

      in_run  = (state_q == RUN);
      redir   = redirect & in_run;
      // A new request only starts when the buffer slot is free or being emptied this cycle.
      launch  = ~rst & in_run & ~busy_q & (~valid_q | ~dec_stall) & ~redirect;
      imem_rd = busy_q | launch;
      // The address stays frozen on the launched PC even if a redirect moves pc_q mid-request.
      imem_addr = busy_q ? addr_q : pc_q;
      done    = imem_rd & imem_done;
      capture = done & ~squash_q & ~redir;
      consume = valid_q & ~dec_stall;

      if (launch) begin
         addr_d = pc_q;
      end

      if (done) begin
         busy_d   = 1'b0;
         squash_d = 1'b0;
      end else if (launch) begin
         busy_d = 1'b1;
      end else if (redir & busy_q) begin
         squash_d = 1'b1;
      end

      if (redir) begin
         valid_d = 1'b0;
`ifdef FETCH_MISALIGN_EN
         pc_d = next_pc;
         if (next_pc[0]) begin
            fetch_err_d = 1'b1;
            state_d     = HALT;
            halted_d    = 1'b1;
         end
`else
         pc_d = {next_pc[15:1], 1'b0};
`endif
      end else if (capture) begin
         instr_d  = imem_data;
         pc_inc_d = pc_q + 16'd2;
         pc_d     = pc_q + 16'd2;
         valid_d  = 1'b1;
         if (imem_data[15:11] == HALT_OP) begin
            state_d  = HALT;
            halted_d = 1'b1;
         end
      end else if (consume) begin
         valid_d = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= RUN;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         instr_q  <= NOP;
         pc_inc_q <= 16'h0000;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         squash_q <= 1'b0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         instr_q  <= instr_d;
         pc_inc_q <= pc_inc_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         squash_q <= squash_d;
         halted_q <= halted_d;
      end
   end

`ifdef FETCH_MISALIGN_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_err_q <= 1'b0;
      end else begin
         fetch_err_q <= fetch_err_d;
      end
   end
   assign fetch_err = fetch_err_q;
`else
   assign fetch_err = 1'b0;
`endif

   assign instr       = instr_q;
   assign pc_inc      = pc_inc_q;
   assign instr_valid = valid_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit with a variable-latency instruction memory model.
// Build with FETCH_MISALIGN_EN defined to exercise the misaligned-redirect halt path.
module tb_fetch_pc_unit;

   logic        clk;
   logic        rst;
   logic [15:0] next_pc;
   logic        redirect;
   logic        dec_stall;
   logic        imem_rd;
   logic [15:0] imem_addr;
   logic        imem_done;
   logic [15:0] imem_data;
   logic [15:0] instr;
   logic [15:0] pc_inc;
   logic        instr_valid;
   logic        halted;
   logic        fetch_err;

   int          checks;
   int          errors;
   int          mem_lat;
   int          wait_cnt;
   logic [15:0] halt_addr;

   fetch_pc_unit dut (
      .clk         (clk),
      .rst         (rst),
      .next_pc     (next_pc),
      .redirect    (redirect),
      .dec_stall   (dec_stall),
      .imem_rd     (imem_rd),
      .imem_addr   (imem_addr),
      .imem_done   (imem_done),
      .imem_data   (imem_data),
      .instr       (instr),
      .pc_inc      (pc_inc),
      .instr_valid (instr_valid),
      .halted      (halted),
      .fetch_err   (fetch_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word at address a is {8'h40 + a[8:1], 8'h00}; halt_addr returns the HALT opcode word.
   function automatic logic [15:0] mem_word(input logic [15:0] a, input logic [15:0] h);
      logic [7:0] hi;
      if (a == h) return 16'h0000;
      hi = 8'h40 + a[8:1];
      return {hi, 8'h00};
   endfunction

   assign imem_done = imem_rd && (wait_cnt >= mem_lat - 1);
   assign imem_data = mem_word(imem_addr, halt_addr);

   always @(posedge clk or posedge rst) begin
      if (rst)                      wait_cnt <= 0;
      else if (imem_rd && !imem_done) wait_cnt <= wait_cnt + 1;
      else                          wait_cnt <= 0;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input int lat);
      rst       = 1'b1;
      redirect  = 1'b0;
      dec_stall = 1'b0;
      next_pc   = 16'h0000;
      mem_lat   = lat;
      halt_addr = 16'hFFFF;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      do_reset(1);
      rst = 1'b1;
      #1;
      checks++; if (instr !== 16'h0800) begin errors++; $display("FAIL reset_instr got %h want 0800", instr); end
      checks++; if (pc_inc !== 16'h0000) begin errors++; $display("FAIL reset_pc_inc got %h want 0000", pc_inc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", instr_valid); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
      checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL reset_fetch_err got %b want 0", fetch_err); end
      checks++; if (imem_rd !== 1'b0) begin errors++; $display("FAIL reset_imem_rd got %b want 0", imem_rd); end
      // Async reset must clear a valid instruction without waiting for an edge.
      do_reset(1);
      tick();
      tick();
      rst = 1'b1;
      #1;
      checks++; if (instr_valid !== 1'b0 || pc_inc !== 16'h0000) begin
         errors++; $display("FAIL async_reset got valid=%b pc_inc=%h want 0/0000", instr_valid, pc_inc);
      end
      rst = 1'b0;
   endtask

   task automatic test_back_to_back();
      logic [7:0] hi;
      do_reset(1);
      for (int i = 0; i < 3; i++) begin
         checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'(2 * i)) begin
            errors++; $display("FAIL b2b_launch%0d got rd=%b addr=%h want 1/%h", i, imem_rd, imem_addr, 16'(2 * i));
         end
         tick();
         hi = 8'h40 + 8'(i);
         checks++; if (instr_valid !== 1'b1 || pc_inc !== 16'(2 * i + 2) || instr !== {hi, 8'h00}) begin
            errors++; $display("FAIL b2b_capture%0d got v=%b pc_inc=%h instr=%h want 1/%h/%h",
                               i, instr_valid, pc_inc, instr, 16'(2 * i + 2), {hi, 8'h00});
         end
      end
   endtask

   // Continues from test_back_to_back: instr 4200 with pc_inc 0006 is buffered.
   task automatic test_stall();
      dec_stall = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (imem_rd !== 1'b0 || instr_valid !== 1'b1 || instr !== 16'h4200 || pc_inc !== 16'h0006) begin
            errors++; $display("FAIL stall%0d got rd=%b v=%b instr=%h pc_inc=%h want 0/1/4200/0006",
                               k, imem_rd, instr_valid, instr, pc_inc);
         end
         tick();
      end
      dec_stall = 1'b0;
      #1;
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0006) begin
         errors++; $display("FAIL stall_release got rd=%b addr=%h want 1/0006", imem_rd, imem_addr);
      end
      tick();
      checks++; if (instr_valid !== 1'b1 || instr !== 16'h4300 || pc_inc !== 16'h0008) begin
         errors++; $display("FAIL stall_next got v=%b instr=%h pc_inc=%h want 1/4300/0008", instr_valid, instr, pc_inc);
      end
   endtask

   task automatic test_redirect_squash();
      do_reset(3);
      for (int i = 0; i < 20 && !(imem_rd && imem_addr == 16'h0004); i++) tick();
      checks++; if (!(imem_rd === 1'b1 && imem_addr === 16'h0004)) begin
         errors++; $display("FAIL squash_wait_launch got rd=%b addr=%h want 1/0004", imem_rd, imem_addr);
      end
      tick();
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0004 || imem_done !== 1'b0) begin
         errors++; $display("FAIL squash_inflight got rd=%b addr=%h done=%b want 1/0004/0", imem_rd, imem_addr, imem_done);
      end
      redirect = 1'b1;
      next_pc  = 16'h0100;
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0004 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL squash_hold got rd=%b addr=%h v=%b want 1/0004/0", imem_rd, imem_addr, instr_valid);
      end
      tick();
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0100 || instr_valid !== 1'b0) begin
         errors++; $display("FAIL squash_relaunch got rd=%b addr=%h v=%b want 1/0100/0", imem_rd, imem_addr, instr_valid);
      end
      tick();
      tick();
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_inc !== 16'h0102 || instr !== 16'hC000) begin
         errors++; $display("FAIL squash_target got v=%b pc_inc=%h instr=%h want 1/0102/C000", instr_valid, pc_inc, instr);
      end
   endtask

   task automatic test_halt();
      do_reset(1);
      halt_addr = 16'h0006;
      #1;
      tick();
      tick();
      tick();
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0006) begin
         errors++; $display("FAIL halt_launch got rd=%b addr=%h want 1/0006", imem_rd, imem_addr);
      end
      tick();
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b1 || pc_inc !== 16'h0008 || instr !== 16'h0000 || imem_rd !== 1'b0) begin
         errors++; $display("FAIL halt_capture got h=%b v=%b pc_inc=%h instr=%h rd=%b want 1/1/0008/0000/0",
                            halted, instr_valid, pc_inc, instr, imem_rd);
      end
      redirect = 1'b1;
      next_pc  = 16'h0040;
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || pc_inc !== 16'h0008 || imem_rd !== 1'b0) begin
         errors++; $display("FAIL halt_redirect got h=%b v=%b pc_inc=%h rd=%b want 1/0/0008/0", halted, instr_valid, pc_inc, imem_rd);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         checks++; if (imem_rd !== 1'b0 || halted !== 1'b1) begin
            errors++; $display("FAIL halt_idle%0d got rd=%b h=%b want 0/1", k, imem_rd, halted);
         end
      end
   endtask

   task automatic test_wrap();
      do_reset(1);
      redirect = 1'b1;
      next_pc  = 16'hFFFE;
      #1;
      checks++; if (imem_rd !== 1'b0) begin
         errors++; $display("FAIL wrap_no_launch got rd=%b want 0", imem_rd);
      end
      tick();
      redirect = 1'b0;
      #1;
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'hFFFE) begin
         errors++; $display("FAIL wrap_launch got rd=%b addr=%h want 1/FFFE", imem_rd, imem_addr);
      end
      tick();
      checks++; if (instr_valid !== 1'b1 || pc_inc !== 16'h0000 || instr !== 16'h3F00 || imem_addr !== 16'h0000) begin
         errors++; $display("FAIL wrap_capture got v=%b pc_inc=%h instr=%h addr=%h want 1/0000/3F00/0000",
                            instr_valid, pc_inc, instr, imem_addr);
      end
   endtask

   task automatic test_misalign();
      do_reset(1);
      redirect = 1'b1;
      next_pc  = 16'h0011;
      tick();
      redirect = 1'b0;
      #1;
`ifdef FETCH_MISALIGN_EN
      checks++; if (fetch_err !== 1'b1 || halted !== 1'b1 || imem_rd !== 1'b0) begin
         errors++; $display("FAIL misalign_err got err=%b h=%b rd=%b want 1/1/0", fetch_err, halted, imem_rd);
      end
`else
      checks++; if (imem_rd !== 1'b1 || imem_addr !== 16'h0010 || fetch_err !== 1'b0 || halted !== 1'b0) begin
         errors++; $display("FAIL misalign_force got rd=%b addr=%h err=%b h=%b want 1/0010/0/0",
                            imem_rd, imem_addr, fetch_err, halted);
      end
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b1;
      redirect  = 1'b0;
      dec_stall = 1'b0;
      next_pc   = 16'h0000;
      mem_lat   = 1;
      halt_addr = 16'hFFFF;
      test_reset();
      test_back_to_back();
      test_stall();
      test_redirect_squash();
      test_halt();
      test_wrap();
      test_misalign();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
